// File: rtl/ir_nec_decode.sv
// NEC infrared frame decoder driven by pre-detected IRDA_RXD edge pulses.
// Define IR_CHECKSUM_EN to reject frames whose complement bytes do not match.
module ir_nec_decode #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  // Divides every timing window; 1 gives real NEC timing at 50 MHz.
  parameter int unsigned WIN_DIV     = 1
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       ir_neg,
  input  logic       ir_pos,
  output logic [7:0] ir_addr,
  output logic [7:0] ir_cmd,
  output logic       ir_valid,
  output logic       ir_repeat,
  output logic       ir_err
);

  localparam logic [19:0] TimeoutVal = 20'(TIMEOUT_CYC);
  localparam logic [19:0] LeadMin    = 20'(400000 / WIN_DIV);
  localparam logic [19:0] LeadMax    = 20'(500000 / WIN_DIV);
  localparam logic [19:0] FrmGapMin  = 20'(200000 / WIN_DIV);
  localparam logic [19:0] FrmGapMax  = 20'(250000 / WIN_DIV);
  localparam logic [19:0] RptGapMin  = 20'(100000 / WIN_DIV);
  localparam logic [19:0] RptGapMax  = 20'(125000 / WIN_DIV);
  localparam logic [19:0] MarkMin    = 20'(20000 / WIN_DIV);
  localparam logic [19:0] MarkMax    = 20'(36000 / WIN_DIV);
  localparam logic [19:0] OneMin     = 20'(70000 / WIN_DIV);
  localparam logic [19:0] OneMax     = 20'(100000 / WIN_DIV);

  typedef enum logic [2:0] {
    StIdle, StLeadLow, StLeadHigh, StBitLow, StBitHigh, StStopLow, StRptLow
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        seen_q;
  logic        valid_pend_q;
  logic        edge_ok, accept, rpt_ev, err_ev, csum_ok;
  logic        is_mark, is_one;

  function automatic logic in_win(input logic [19:0] v, input logic [19:0] lo,
                                  input logic [19:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

`ifdef IR_CHECKSUM_EN
  assign csum_ok = (shreg_q[15:8] == ~shreg_q[7:0]) && (shreg_q[31:24] == ~shreg_q[23:16]);
`else
  assign csum_ok = 1'b1;
`endif

  assign is_mark = in_win(cnt_q, MarkMin, MarkMax);
  assign is_one  = in_win(cnt_q, OneMin, OneMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    edge_ok   = 1'b0;
    accept    = 1'b0;
    rpt_ev    = 1'b0;
    err_ev    = 1'b0;

    if (state_q == StIdle) begin
      if (ir_neg && !ir_pos) begin
        state_d = StLeadLow;
        edge_ok = 1'b1;
      end
    end else if (ir_pos && ir_neg) begin
      err_ev = 1'b1;
    end else if (ir_pos || ir_neg) begin
      // Each state accepts one polarity; the other one falls through to an error.
      case (state_q)
        StLeadLow: begin
          if (ir_pos && in_win(cnt_q, LeadMin, LeadMax)) begin
            state_d = StLeadHigh;
            edge_ok = 1'b1;
          end else err_ev = 1'b1;
        end
        StLeadHigh: begin
          if (ir_neg && in_win(cnt_q, FrmGapMin, FrmGapMax)) begin
            state_d   = StBitLow;
            bit_cnt_d = '0;
            edge_ok   = 1'b1;
          end else if (ir_neg && in_win(cnt_q, RptGapMin, RptGapMax)) begin
            state_d = StRptLow;
            edge_ok = 1'b1;
          end else err_ev = 1'b1;
        end
        StBitLow: begin
          if (ir_pos && is_mark) begin
            state_d = StBitHigh;
            edge_ok = 1'b1;
          end else err_ev = 1'b1;
        end
        StBitHigh: begin
          if (ir_neg && (is_mark || is_one)) begin
            shreg_d   = {is_one, shreg_q[31:1]};
            bit_cnt_d = bit_cnt_q + 6'd1;
            state_d   = (bit_cnt_q == 6'd31) ? StStopLow : StBitLow;
            edge_ok   = 1'b1;
          end else err_ev = 1'b1;
        end
        StStopLow: begin
          if (ir_pos && is_mark && csum_ok) begin
            accept  = 1'b1;
            state_d = StIdle;
            edge_ok = 1'b1;
          end else err_ev = 1'b1;
        end
        StRptLow: begin
          if (ir_pos && is_mark) begin
            state_d = StIdle;
            edge_ok = 1'b1;
            if (seen_q) rpt_ev = 1'b1;
            else        err_ev = 1'b1;
          end else err_ev = 1'b1;
        end
        default: err_ev = 1'b1;
      endcase
    end else if (cnt_q == TimeoutVal) begin
      err_ev = 1'b1;
    end

    if (err_ev) state_d = StIdle;

    if (edge_ok || state_d == StIdle) cnt_d = '0;
    else if (cnt_q != TimeoutVal)     cnt_d = cnt_q + 20'd1;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      seen_q       <= 1'b0;
      valid_pend_q <= 1'b0;
      ir_addr      <= '0;
      ir_cmd       <= '0;
      ir_valid     <= 1'b0;
      ir_repeat    <= 1'b0;
      ir_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      seen_q       <= seen_q | accept;
      // Address/command settle one cycle before ir_valid announces them.
      valid_pend_q <= accept;
      ir_valid     <= valid_pend_q;
      ir_repeat    <= rpt_ev;
      ir_err       <= err_ev;
      if (accept) begin
        ir_addr <= shreg_q[7:0];
        ir_cmd  <= shreg_q[23:16];
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_decode.sv
// Self-checking bench for ir_nec_decode with timing windows scaled down by 1000.
// A protocol model predicts output pulses per cycle from the edge durations sent.
module tb_ir_nec_decode;

  localparam int unsigned DIV = 1000;
  localparam int unsigned TMO = 2000;
  // NEC windows in cycles after scaling (50 MHz values / 1000).
  localparam int LEAD_LO = 400, LEAD_HI = 500, FGAP_LO = 200, FGAP_HI = 250;
  localparam int RGAP_LO = 100, RGAP_HI = 125, MK_LO = 20, MK_HI = 36;
  localparam int S1_LO = 70, S1_HI = 100;
  // Nominal NEC timings: 9 ms, 4.5 ms, 2.25 ms, 560 us, 1.69 ms.
  localparam int LEAD = 450, FGAP = 225, RGAP = 112, MARK = 28, S0 = 28, S1 = 84;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ir_neg = 1'b0;
  logic       ir_pos = 1'b0;
  logic [7:0] ir_addr, ir_cmd;
  logic       ir_valid, ir_repeat, ir_err;

  ir_nec_decode #(.TIMEOUT_CYC(TMO), .WIN_DIV(DIV)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .ir_neg    (ir_neg),
    .ir_pos    (ir_pos),
    .ir_addr   (ir_addr),
    .ir_cmd    (ir_cmd),
    .ir_valid  (ir_valid),
    .ir_repeat (ir_repeat),
    .ir_err    (ir_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {bit pos; bit both; int dur;} edge_t;
  edge_t      tx[$];
  int         exp_ev[int];      // cycle -> 1 valid, 2 repeat, 3 err
  logic [15:0] exp_chg[int];    // cycle -> {addr, cmd}
  bit         seen;
  int         last_n;
  int         checks, errors;
  int         n_valid, n_rpt, n_err, err_cyc;

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic compare_loop();
    logic [7:0]  ea, ec;
    logic [18:0] got, want;
    int          ev;
    ea = '0;
    ec = '0;
    forever begin
      @(negedge CLOCK_50);
      ev = 0;
      if (!rst_n) begin
        ea = '0;
        ec = '0;
      end else begin
        if (exp_chg.exists(cyc)) {ea, ec} = exp_chg[cyc];
        if (exp_ev.exists(cyc)) ev = exp_ev[cyc];
      end
      want = {ev == 1, ev == 2, ev == 3, ea, ec};
      got  = {ir_valid, ir_repeat, ir_err, ir_addr, ir_cmd};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs cyc %0d: got v/r/e=%b%b%b addr=%h cmd=%h, want v/r/e=%b%b%b addr=%h cmd=%h",
                 cyc, got[18], got[17], got[16], got[15:8], got[7:0],
                 want[18], want[17], want[16], want[15:8], want[7:0]);
      end
      if (ir_valid) n_valid++;
      if (ir_repeat) n_rpt++;
      if (ir_err) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  endtask

  // 0: transmission ended before this edge, 1: edge fits, 2: edge violates.
  function automatic int step(input int i, input bit want_pos, input int lo, input int hi);
    if (i >= tx.size()) return 0;
    if (tx[i].both || tx[i].pos != want_pos || tx[i].dur < lo || tx[i].dur > hi) return 2;
    return 1;
  endfunction

  // Decodes the queued transmission from its durations and schedules expected outputs.
  function automatic void predict();
    int          at_n[$];
    int          p = last_n;
    int          i = 1;
    int          st;
    bit          ok;
    logic [31:0] w = '0;
    foreach (tx[k]) begin
      p += tx[k].dur + 1;
      at_n.push_back(p);
    end
    st = step(i, 1, LEAD_LO, LEAD_HI);
    if (st == 1) begin
      i++;
      if (step(i, 0, FGAP_LO, FGAP_HI) == 1) begin
        i++;
        for (int b = 0; b < 32 && st == 1; b++) begin
          st = step(i, 1, MK_LO, MK_HI);
          if (st == 1) begin
            i++;
            st = step(i, 0, S1_LO, S1_HI);
            if (st == 1) w[b] = 1'b1;
            else st = step(i, 0, MK_LO, MK_HI);
            if (st == 1) i++;
          end
        end
        if (st == 1) st = step(i, 1, MK_LO, MK_HI);
        if (st == 1) begin
`ifdef IR_CHECKSUM_EN
          ok = (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
`else
          ok = 1'b1;
`endif
          if (ok) begin
            exp_chg[at_n[i]] = {w[7:0], w[23:16]};
            exp_ev[at_n[i] + 1] = 1;
            seen = 1'b1;
          end else exp_ev[at_n[i]] = 3;
        end
      end else if (step(i, 0, RGAP_LO, RGAP_HI) == 1) begin
        i++;
        st = step(i, 1, MK_LO, MK_HI);
        if (st == 1) exp_ev[at_n[i]] = seen ? 2 : 3;
      end else begin
        st = step(i, 0, FGAP_LO, FGAP_HI);
      end
    end
    if (st == 0) exp_ev[at_n[at_n.size() - 1] + TMO + 1] = 3;
    else if (st == 2) exp_ev[at_n[i]] = 3;
  endfunction

  task automatic add(input bit p, input int d);
    tx.push_back('{pos: p, both: 1'b0, dur: d});
  endtask

  task automatic build_frame(input logic [7:0] a, input logic [7:0] na, input logic [7:0] c,
                             input logic [7:0] nc, input int lead, input int gap,
                             input int mark, input int s0, input int s1);
    logic [31:0] word;
    word = {nc, c, na, a};
    tx.delete();
    add(0, 10);
    add(1, lead);
    add(0, gap);
    for (int b = 0; b < 32; b++) begin
      add(1, mark);
      add(0, word[b] ? s1 : s0);
    end
    add(1, mark);
  endtask

  task automatic drive();
    int target;
    foreach (tx[k]) begin
      target = last_n + tx[k].dur + 1;
      while (cyc < target - 1) @(negedge CLOCK_50);
      if (tx[k].both) begin
        ir_pos = 1'b1;
        ir_neg = 1'b1;
      end else if (tx[k].pos) ir_pos = 1'b1;
      else ir_neg = 1'b1;
      @(negedge CLOCK_50);
      ir_pos = 1'b0;
      ir_neg = 1'b0;
      last_n = cyc;
    end
  endtask

  task automatic send(input bit model);
    @(negedge CLOCK_50);
    last_n = cyc;
    if (model) predict();
    drive();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic reset_assert();
    @(posedge CLOCK_50);
    #2 rst_n = 1'b0;
    exp_ev.delete();
    exp_chg.delete();
    seen = 1'b0;
    wait_cyc(3);
  endtask

  task automatic reset_release();
    @(posedge CLOCK_50);
    #2 rst_n = 1'b1;
    wait_cyc(2);
  endtask

  int v0, r0, e0;
  task automatic mark_counts();
    v0 = n_valid;
    r0 = n_rpt;
    e0 = n_err;
  endtask

  initial begin
    fork
      compare_loop();
      begin
        wait_cyc(120000);
        $display("FAIL watchdog: got cycle %0d, want finish earlier", cyc);
        $fatal(1);
      end
    join_none

    wait_cyc(3);
    lit("rst_addr", ir_addr, 0);
    lit("rst_cmd", ir_cmd, 0);
    lit("rst_pulses", {ir_valid, ir_repeat, ir_err}, 0);
    reset_release();

    // Repeat code with no frame since reset.
    mark_counts();
    tx.delete(); add(0, 10); add(1, LEAD); add(0, RGAP); add(1, MARK);
    send(1); wait_cyc(5);
    lit("rpt_after_rst_err", n_err - e0, 1);
    lit("rpt_after_rst_rpt", n_rpt - r0, 0);

    // Reference frame 00/FF/45/BA.
    mark_counts();
    build_frame(8'h00, 8'hFF, 8'h45, 8'hBA, LEAD, FGAP, MARK, S0, S1);
    send(1); wait_cyc(5);
    lit("frame_valid_cnt", n_valid - v0, 1);
    lit("frame_err_cnt", n_err - e0, 0);
    lit("frame_addr", ir_addr, 8'h00);
    lit("frame_cmd", ir_cmd, 8'h45);

    // Repeat code after an accepted frame.
    mark_counts();
    tx.delete(); add(0, 10); add(1, LEAD); add(0, RGAP); add(1, MARK);
    send(1); wait_cyc(5);
    lit("rpt_cnt", n_rpt - r0, 1);
    lit("rpt_addr", ir_addr, 8'h00);
    lit("rpt_cmd", ir_cmd, 8'h45);

    // Corrupted inverted command.
    mark_counts();
    build_frame(8'h00, 8'hFF, 8'h45, 8'hBB, LEAD, FGAP, MARK, S0, S1);
    send(1); wait_cyc(5);
`ifdef IR_CHECKSUM_EN
    lit("csum_err", n_err - e0, 1);
    lit("csum_valid", n_valid - v0, 0);
`else
    lit("nocsum_valid", n_valid - v0, 1);
    lit("nocsum_cmd", ir_cmd, 8'h45);
`endif

    // 7 ms leader mark, then a good frame with cmd 16.
    mark_counts();
    tx.delete(); add(0, 10); add(1, 350);
    send(1); wait_cyc(5);
    lit("short_lead_err", n_err - e0, 1);
    lit("short_lead_err_cyc", err_cyc - last_n, 0);  // visible in the cycle after ir_pos
    build_frame(8'h00, 8'hFF, 8'h16, 8'hE9, LEAD, FGAP, MARK, S0, S1);
    send(1); wait_cyc(5);
    lit("after_err_cmd", ir_cmd, 8'h16);

    // Window edges: every duration at its minimum or maximum.
    build_frame(8'hA5, 8'h5A, 8'h3C, 8'hC3, LEAD_LO, FGAP_HI, MK_LO, MK_HI, S1_HI);
    send(1); wait_cyc(5);
    lit("bound1_addr", ir_addr, 8'hA5);
    build_frame(8'h81, 8'h7E, 8'h7E, 8'h81, LEAD_HI, FGAP_LO, MK_HI, MK_LO, S1_LO);
    send(1); wait_cyc(5);
    lit("bound2_cmd", ir_cmd, 8'h7E);

    // Just outside the windows.
    mark_counts();
    tx.delete(); add(0, 10); add(1, 501);
    send(1); wait_cyc(5);
    tx.delete(); add(0, 10); add(1, 399);
    send(1); wait_cyc(5);
    tx.delete(); add(0, 10); add(1, LEAD); add(0, FGAP); add(1, 37);
    send(1); wait_cyc(5);
    tx.delete(); add(0, 10); add(1, LEAD); add(0, FGAP); add(1, MARK); add(0, 50);
    send(1); wait_cyc(5);
    lit("window_errs", n_err - e0, 4);

    // Leader then silence.
    mark_counts();
    tx.delete(); add(0, 10); add(1, LEAD);
    send(1); wait_cyc(TMO + 20);
    lit("tmo_err", n_err - e0, 1);
    lit("tmo_err_cyc", err_cyc - last_n, TMO + 1);

    // Both edges together in BIT_HIGH, wrong polarity in LEAD_LOW.
    mark_counts();
    tx.delete(); add(0, 10); add(1, LEAD); add(0, FGAP); add(1, MARK);
    tx.push_back('{pos: 1'b0, both: 1'b1, dur: S0});
    send(1); wait_cyc(5);
    tx.delete(); add(0, 10); add(0, 100);
    send(1); wait_cyc(5);
    lit("clash_polarity_errs", n_err - e0, 2);

    // Both edges, then a lone ir_pos, while idle: nothing happens.
    mark_counts();
    tx.delete();
    tx.push_back('{pos: 1'b0, both: 1'b1, dur: 10});
    add(1, 10);
    send(0); wait_cyc(TMO + 20);
    lit("idle_pulses", (n_valid - v0) + (n_rpt - r0) + (n_err - e0), 0);

    // Reset after 16 data bits, then a full frame.
    mark_counts();
    build_frame(8'h12, 8'hED, 8'h34, 8'hCB, LEAD, FGAP, MARK, S0, S1);
    while (tx.size() > 35) void'(tx.pop_back());
    send(1);
    reset_assert();
    lit("midrst_addr", ir_addr, 0);
    lit("midrst_cmd", ir_cmd, 0);
    reset_release();
    lit("midrst_pulses", (n_valid - v0) + (n_rpt - r0) + (n_err - e0), 0);
    build_frame(8'h12, 8'hED, 8'h34, 8'hCB, LEAD, FGAP, MARK, S0, S1);
    send(1); wait_cyc(5);
    lit("post_rst_valid", n_valid - v0, 1);
    lit("post_rst_addr", ir_addr, 8'h12);
    lit("post_rst_cmd", ir_cmd, 8'h34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
